// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one instruction-memory request at a
// time, holds the fetched word for decode and selects the next PC on consume.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] imm_ext,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {IDLE, FETCH, DECODE} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic        r_imem_req;
  logic [31:0] r_retired;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;

  assign w_pc_plus4 = r_pc + 32'd4;

  // Jump beats a taken branch; branch offset is a word offset, wrap is silent.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (jump)
      w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    else if (branch && zero)
      w_next_pc = w_pc_plus4 + {imm_ext[29:0], 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= 32'd0;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b0;
      r_retired     <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state    <= FETCH;
          r_imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_imem_req    <= 1'b0;
            r_state       <= DECODE;
          end
        end
        DECODE: begin
          if (!stall) begin
            r_pc          <= w_next_pc;
            r_instr_valid <= 1'b0;
            r_retired     <= r_retired + 32'd1;
            r_imem_req    <= 1'b1;
            r_state       <= FETCH;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign op          = r_instr[31:26];
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign retired     = r_retired;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential flow, branch/jump selection,
// wait states, decode stall and asynchronous reset during a fetch.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic [31:0] instr;
  logic [5:0]  op;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        jump;
  logic        branch;
  logic        zero;
  logic [31:0] imm_ext;
  logic [31:0] retired;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .instr(instr), .op(op), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4),
    .jump(jump), .branch(branch), .zero(zero), .imm_ext(imm_ext),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0; stall = 1'b0;
    jump = 1'b0; branch = 1'b0; zero = 1'b0; imm_ext = 32'd0;
    #12;
    chk("rst_req",     {31'd0, imem_req}, 32'd0);
    chk("rst_pc",      pc, 32'd0);
    chk("rst_instr",   instr, 32'd0);
    chk("rst_valid",   {31'd0, instr_valid}, 32'd0);
    chk("rst_retired", retired, 32'd0);

    // Ready high from the start; IDLE must ignore it
    imem_ready = 1'b1; imem_rdata = 32'h0000_0020; rst_n = 1'b1;
    #1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    step();
    chk("f0_req",   {31'd0, imem_req}, 32'd1);
    chk("f0_addr",  imem_addr, 32'h0);
    chk("f0_valid", {31'd0, instr_valid}, 32'd0);
    step();
    chk("d0_valid", {31'd0, instr_valid}, 32'd1);
    chk("d0_instr", instr, 32'h0000_0020);
    chk("d0_op",    {26'd0, op}, 32'd0);
    chk("d0_req",   {31'd0, imem_req}, 32'd0);
    chk("d0_pc4",   pc_plus4, 32'h4);
    imem_rdata = 32'h0000_0024;
    step();
    chk("f1_addr",    imem_addr, 32'h4);
    chk("f1_req",     {31'd0, imem_req}, 32'd1);
    chk("f1_retired", retired, 32'd1);
    chk("f1_valid",   {31'd0, instr_valid}, 32'd0);
    step();
    chk("d1_instr", instr, 32'h0000_0024);
    chk("d1_req",   {31'd0, imem_req}, 32'd0);
    imem_rdata = 32'h0800_0010;
    step();
    chk("f2_addr",    imem_addr, 32'h8);
    chk("f2_retired", retired, 32'd2);
    step();
    chk("d2_instr", instr, 32'h0800_0010);
    chk("d2_op",    {26'd0, op}, 32'd2);
    jump = 1'b1; imem_rdata = 32'h1000_FFFE;
    step();
    chk("jmp40_addr",    imem_addr, 32'h40);
    chk("jmp40_retired", retired, 32'd3);
    jump = 1'b0;
    step();
    branch = 1'b1; zero = 1'b1; imm_ext = 32'hFFFF_FFFE; imem_rdata = 32'h1000_0000;
    step();
    chk("br_taken_addr", imem_addr, 32'h3C);
    branch = 1'b0; zero = 1'b0;
    step();
    branch = 1'b1; zero = 1'b1; imm_ext = 32'd0;
    step();
    chk("br_zero_off", imem_addr, 32'h40);
    branch = 1'b0; zero = 1'b0;
    step();
    branch = 1'b1; zero = 1'b0; imm_ext = 32'hFFFF_FFFE;
    step();
    chk("br_not_taken", imem_addr, 32'h44);
    step();
    branch = 1'b1; zero = 1'b1; imm_ext = 32'h03FF_FFEE; imem_rdata = 32'h0800_0100;
    step();
    chk("br_far_addr", imem_addr, 32'h1000_0000);
    branch = 1'b0; zero = 1'b0;
    step();
    chk("dj_instr", instr, 32'h0800_0100);
    jump = 1'b1; branch = 1'b1; zero = 1'b1; imm_ext = 32'hFFFF_FFFE; imem_ready = 1'b0;
    step();
    chk("jmp_prio_addr", imem_addr, 32'h1000_0400);
    chk("jmp_retired",   retired, 32'd8);
    jump = 1'b0; branch = 1'b0; zero = 1'b0; stall = 1'b1;

    // Wait states: stall during FETCH must not matter either
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ws_req",   {31'd0, imem_req}, 32'd1);
      chk("ws_addr",  imem_addr, 32'h1000_0400);
      chk("ws_valid", {31'd0, instr_valid}, 32'd0);
      chk("ws_instr", instr, 32'h0800_0100);
    end
    stall = 1'b0; imem_rdata = 32'hDEAD_BEEF; imem_ready = 1'b1;
    step();
    chk("ws_cap_instr", instr, 32'hDEAD_BEEF);
    chk("ws_cap_valid", {31'd0, instr_valid}, 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("st_instr",   instr, 32'hDEAD_BEEF);
      chk("st_pc",      pc, 32'h1000_0400);
      chk("st_retired", retired, 32'd8);
      chk("st_req",     {31'd0, imem_req}, 32'd0);
      chk("st_valid",   {31'd0, instr_valid}, 32'd1);
    end
    stall = 1'b0; branch = 1'b1; zero = 1'b1; imm_ext = 32'h3BFF_FF01; imem_ready = 1'b0;
    step();
    chk("wrap_addr",    imem_addr, 32'h8);
    chk("wrap_retired", retired, 32'd9);
    chk("wrap_req",     {31'd0, imem_req}, 32'd1);
    branch = 1'b0; zero = 1'b0;

    // Asynchronous reset mid-fetch, then a late ready pulse while in IDLE
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req",     {31'd0, imem_req}, 32'd0);
    chk("ar_pc",      pc, 32'h0);
    chk("ar_retired", retired, 32'd0);
    chk("ar_valid",   {31'd0, instr_valid}, 32'd0);
    imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
    #2 rst_n = 1'b1;
    #1;
    chk("ar_idle_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk);
    #1;
    imem_ready = 1'b0;
    chk("ar_f_req",     {31'd0, imem_req}, 32'd1);
    chk("ar_f_addr",    imem_addr, 32'h0);
    chk("ar_f_valid",   {31'd0, instr_valid}, 32'd0);
    chk("ar_f_instr",   instr, 32'h0);
    chk("ar_f_retired", retired, 32'd0);
    step();
    chk("ar_hold_req", {31'd0, imem_req}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
